// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides, carry/borrow chaining,
// 1-bit shifts through carry, status flags and an iterative shift-add multiplier.
module alu_seq #(
   parameter int WIDTH = 8,
   parameter int CNTW  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             cout,
   output logic             zero,
   output logic             ovf,
   output logic             illegal
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_ADC = 4'd5;
   localparam logic [3:0] OP_SBB = 4'd6;
   localparam logic [3:0] OP_NOT = 4'd7;
   localparam logic [3:0] OP_SHL = 4'd8;
   localparam logic [3:0] OP_SHR = 4'd9;
   localparam logic [3:0] OP_MUL = 4'd10;

   localparam logic [CNTW-1:0] LAST_CNT = CNTW'(WIDTH - 1);

   logic [1:0]           state_reg;
   logic [CNTW-1:0]      cnt_reg;
   logic [WIDTH-1:0]     mcand_reg;
   logic [WIDTH-1:0]     mplier_reg;
   logic [2*WIDTH-1:0]   acc_reg;
   logic                 ready_en_reg;
   logic                 out_valid_reg;
   logic [WIDTH-1:0]     result_reg;
   logic [WIDTH-1:0]     result_hi_reg;
   logic                 cout_reg;
   logic                 zero_reg;
   logic                 ovf_reg;
   logic                 illegal_reg;

   logic                 accept;
   logic                 take;
   logic [WIDTH:0]       sum_ext;
   logic [WIDTH-1:0]     alu_res;
   logic                 alu_cout;
   logic                 alu_ovf;
   logic                 alu_ill;
   logic [WIDTH:0]       partial;
   logic [2*WIDTH:0]     step_full;
   logic [2*WIDTH-1:0]   acc_step;

   // ready_en_reg keeps in_ready low until the first clock after reset release
   assign in_ready  = ready_en_reg & (state_reg == S_IDLE) & (~out_valid_reg | out_ready);
   assign accept    = in_valid & in_ready;
   assign take      = out_valid_reg & out_ready;

   assign out_valid = out_valid_reg;
   assign result    = result_reg;
   assign result_hi = result_hi_reg;
   assign cout      = cout_reg;
   assign zero      = zero_reg;
   assign ovf       = ovf_reg;
   assign illegal   = illegal_reg;

   always_comb begin
      sum_ext  = '0;
      alu_res  = '0;
      alu_cout = 1'b0;
      alu_ovf  = 1'b0;
      alu_ill  = 1'b0;
      case (op)
         OP_ADD, OP_ADC: begin
            sum_ext  = {1'b0, a} + {1'b0, b} + ((op == OP_ADC) ? (WIDTH+1)'(cin) : '0);
            alu_res  = sum_ext[WIDTH-1:0];
            alu_cout = sum_ext[WIDTH];
            alu_ovf  = (a[WIDTH-1] == b[WIDTH-1]) & (alu_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB, OP_SBB: begin
            // the extra top bit of the widened difference is the borrow
            sum_ext  = {1'b0, a} - {1'b0, b} - ((op == OP_SBB) ? (WIDTH+1)'(cin) : '0);
            alu_res  = sum_ext[WIDTH-1:0];
            alu_cout = sum_ext[WIDTH];
            alu_ovf  = (a[WIDTH-1] != b[WIDTH-1]) & (alu_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_XOR: alu_res = a ^ b;
         OP_NOT: alu_res = ~a;
         OP_SHL: begin
            alu_res  = {a[WIDTH-2:0], cin};
            alu_cout = a[WIDTH-1];
         end
         OP_SHR: begin
            alu_res  = {cin, a[WIDTH-1:1]};
            alu_cout = a[0];
         end
         OP_MUL: alu_res = '0;
         default: alu_ill = 1'b1;
      endcase
   end

   // one shift-add step: add multiplicand into the high half, then shift {carry, acc} right
   always_comb begin
      partial   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (mplier_reg[0] ? {1'b0, mcand_reg} : '0);
      step_full = {partial, acc_reg[WIDTH-1:0]};
      acc_step  = step_full[2*WIDTH:1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= S_IDLE;
         cnt_reg       <= '0;
         mcand_reg     <= '0;
         mplier_reg    <= '0;
         acc_reg       <= '0;
         ready_en_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
         result_reg    <= '0;
         result_hi_reg <= '0;
         cout_reg      <= 1'b0;
         zero_reg      <= 1'b0;
         ovf_reg       <= 1'b0;
         illegal_reg   <= 1'b0;
      end else begin
         ready_en_reg <= 1'b1;
         if (take) begin
            out_valid_reg <= 1'b0;
         end
         case (state_reg)
            S_IDLE: begin
               if (accept) begin
                  if (op == OP_MUL) begin
                     state_reg  <= S_MUL;
                     mcand_reg  <= a;
                     mplier_reg <= b;
                     acc_reg    <= '0;
                     cnt_reg    <= '0;
                  end else begin
                     out_valid_reg <= 1'b1;
                     result_reg    <= alu_res;
                     result_hi_reg <= '0;
                     cout_reg      <= alu_cout;
                     zero_reg      <= (alu_res == '0);
                     ovf_reg       <= alu_ovf;
                     illegal_reg   <= alu_ill;
                  end
               end
            end
            S_MUL: begin
               acc_reg    <= acc_step;
               mplier_reg <= mplier_reg >> 1;
               cnt_reg    <= cnt_reg + CNTW'(1);
               if (cnt_reg == LAST_CNT) begin
                  state_reg     <= S_DONE;
                  out_valid_reg <= 1'b1;
                  result_reg    <= acc_step[WIDTH-1:0];
                  result_hi_reg <= acc_step[2*WIDTH-1:WIDTH];
                  cout_reg      <= 1'b0;
                  zero_reg      <= (acc_step == '0);
                  ovf_reg       <= 1'b0;
                  illegal_reg   <= 1'b0;
               end
            end
            S_DONE: begin
               if (~out_valid_reg | out_ready) begin
                  state_reg <= S_IDLE;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: directed steps plus random ops checked against an
// integer-arithmetic reference model.
module tb_alu_seq;

   localparam int W  = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic [3:0]    op = '0;
   logic          cin = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  result;
   logic [W-1:0]  result_hi;
   logic          cout;
   logic          zero;
   logic          ovf;
   logic          illegal;

   int n_checks = 0;
   int n_fails  = 0;

   logic [W-1:0]  last_res;
   logic [W-1:0]  last_hi;
   logic          last_c;
   logic          last_z;
   logic          last_v;
   logic          last_ill;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] hi;
      logic       c;
      logic       z;
      logic       v;
      logic       ill;
   } exp_t;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(W), .CNTW(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .result_hi (result_hi),
      .cout      (cout),
      .zero      (zero),
      .ovf       (ovf),
      .illegal   (illegal)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // plain integer arithmetic on unsigned/signed interpretations of the operands
   function automatic exp_t model(input int o, input int x, input int y, input int ci);
      exp_t e;
      int   full;
      int   p;
      int   sx;
      int   sy;
      int   sr;
      e    = '0;
      full = 0;
      p    = 0;
      sr   = 0;
      sx   = (x >= 128) ? x - 256 : x;
      sy   = (y >= 128) ? y - 256 : y;
      case (o)
         0: begin full = x + y;      sr = sx + sy;      e.c = (full > 255);   end
         1: begin full = x - y;      sr = sx - sy;      e.c = (x < y);        end
         5: begin full = x + y + ci; sr = sx + sy + ci; e.c = (full > 255);   end
         6: begin full = x - y - ci; sr = sx - sy - ci; e.c = (x < y + ci);   end
         2: full = x & y;
         3: full = x | y;
         4: full = x ^ y;
         7: full = 255 - x;
         8: begin full = x * 2 + ci;    e.c = (x >= 128);     end
         9: begin full = ci * 128 + x / 2; e.c = ((x % 2) == 1); end
         10: begin p = x * y; full = p; e.hi = 8'(p / 256); end
         default: begin full = 0; e.ill = 1'b1; end
      endcase
      e.r = 8'(full);
      e.v = (sr > 127) || (sr < -128);
      e.z = (e.r == 8'd0) && (e.hi == 8'd0);
      return e;
   endfunction

   // issue one op with out_ready=1, check latency and all outputs, then let it drain
   task automatic run_op(input int o, input int x, input int y, input int ci);
      exp_t e;
      int   n;
      int   tmo;
      logic saw_ready;
      op       = 4'(o);
      a        = 8'(x);
      b        = 8'(y);
      cin      = 1'(ci);
      in_valid = 1'b1;
      #1;
      tmo = 0;
      while (!in_ready && tmo < 50) begin
         @(posedge clk);
         #2;
         tmo++;
      end
      check("accept_wait", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      n         = 0;
      saw_ready = 1'b0;
      while (!out_valid && n < 40) begin
         if (in_ready) saw_ready = 1'b1;
         @(posedge clk);
         #1;
         n++;
      end
      e = model(o, x, y, ci);
      check("latency", 32'(n + 1), (o == 10) ? 32'(W + 1) : 32'd1);
      check("out_valid", 32'(out_valid), 32'd1);
      check("result", 32'(result), 32'(e.r));
      check("result_hi", 32'(result_hi), 32'(e.hi));
      check("cout", 32'(cout), 32'(e.c));
      check("zero", 32'(zero), 32'(e.z));
      check("ovf", 32'(ovf), 32'(e.v));
      check("illegal", 32'(illegal), 32'(e.ill));
      if (o == 10) check("mul_busy_ready", 32'(saw_ready), 32'd0);
      $display("op=%0d a=%02h b=%02h cin=%0d -> hi=%02h res=%02h c=%0d z=%0d v=%0d ill=%0d lat=%0d",
               o, x, y, ci, result_hi, result, cout, zero, ovf, illegal, n + 1);
      last_res = result;
      last_hi  = result_hi;
      last_c   = cout;
      last_z   = zero;
      last_v   = ovf;
      last_ill = illegal;
      @(posedge clk);
      #1;
      check("drain", 32'(out_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic stale;

      // reset state
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_result_hi", 32'(result_hi), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_zero", 32'(zero), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      // back-to-back single-cycle stream
      op = 4'd0; a = 8'd3; b = 8'd1; cin = 1'b0; in_valid = 1'b1;
      #1;
      check("stream_ready0", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      check("stream_add_res", 32'(result), 32'd4);
      check("stream_add_valid", 32'(out_valid), 32'd1);
      check("stream_add_cout", 32'(cout), 32'd0);
      $display("stream ADD 3+1 -> %0d", result);
      op = 4'd1; a = 8'd2; b = 8'd1;
      #1;
      check("stream_ready1", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      check("stream_sub_res", 32'(result), 32'd1);
      check("stream_sub_cout", 32'(cout), 32'd0);
      $display("stream SUB 2-1 -> %0d", result);
      op = 4'd5; a = 8'd4; b = 8'd5; cin = 1'b1;
      #1;
      check("stream_ready2", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      check("stream_adc_res", 32'(result), 32'd10);
      check("stream_adc_cout", 32'(cout), 32'd0);
      $display("stream ADC 4+5+1 -> %0d", result);
      in_valid = 1'b0;
      cin      = 1'b0;
      @(posedge clk);
      #1;
      check("stream_drain", 32'(out_valid), 32'd0);

      // arithmetic flag corners
      run_op(0, 128, 128, 0);
      check("add128_res", 32'(last_res), 32'd0);
      check("add128_c", 32'(last_c), 32'd1);
      check("add128_z", 32'(last_z), 32'd1);
      check("add128_v", 32'(last_v), 32'd1);
      run_op(1, 5, 6, 0);
      check("sub56_res", 32'(last_res), 32'd255);
      check("sub56_c", 32'(last_c), 32'd1);
      check("sub56_v", 32'(last_v), 32'd0);
      run_op(0, 127, 1, 0);
      check("add127_res", 32'(last_res), 32'd128);
      check("add127_v", 32'(last_v), 32'd1);

      // multiplier
      run_op(10, 255, 255, 0);
      check("mulff_hi", 32'(last_hi), 32'hFE);
      check("mulff_lo", 32'(last_res), 32'h01);
      run_op(10, 0, 'h77, 0);
      check("mul0_z", 32'(last_z), 32'd1);

      // shifts and illegal opcode
      run_op(8, 'h81, 0, 1);
      check("shl_res", 32'(last_res), 32'h03);
      check("shl_c", 32'(last_c), 32'd1);
      run_op(9, 'h81, 0, 0);
      check("shr_res", 32'(last_res), 32'h40);
      check("shr_c", 32'(last_c), 32'd1);
      run_op(12, 'h5A, 'hA5, 1);
      check("ill_res", 32'(last_res), 32'd0);
      check("ill_flag", 32'(last_ill), 32'd1);

      // backpressure, then transfer and new accept on the same edge
      out_ready = 1'b0;
      op = 4'd4; a = 8'hF0; b = 8'hFF; in_valid = 1'b1;
      #1;
      check("bp_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_result", 32'(result), 32'h0F);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         $display("backpressure cycle %0d: res=%02h in_ready=%0d", i, result, in_ready);
         @(posedge clk);
         #1;
      end
      op = 4'd0; a = 8'd1; b = 8'd2; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check("swap_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("swap_valid", 32'(out_valid), 32'd1);
      check("swap_result", 32'(result), 32'd3);
      $display("swap: new res=%02h", result);
      @(posedge clk);
      #1;
      check("swap_drain", 32'(out_valid), 32'd0);

      // reset during the 4th multiply iteration
      op = 4'd10; a = 8'h0D; b = 8'h0B; in_valid = 1'b1;
      #1;
      check("rmul_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rmul_valid", 32'(out_valid), 32'd0);
      check("rmul_result", 32'(result), 32'd0);
      check("rmul_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rmul_post_ready", 32'(in_ready), 32'd1);
      stale = 1'b0;
      for (int i = 0; i < 15; i++) begin
         if (out_valid) stale = 1'b1;
         @(posedge clk);
         #1;
      end
      check("rmul_no_stale", 32'(stale), 32'd0);
      $display("reset mid-MUL: stale=%0d", stale);

      // random ops against the model
      for (int i = 0; i < 60; i++) begin
         run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 8-bit combinational ALU. It has a WIDTH-bit datapath with valid/ready handshakes on the input and output sides.
- It adds carry/borrow chaining ops, 1-bit shifts through carry, status flags, and an iterative shift-add multiplier that takes WIDTH cycles.
- It sits between the operand/decode stage and the writeback register file. It holds one result at a time and stalls upstream until that result is taken.

Parameters:
- WIDTH, 8: operand/result width; must be ≥ 4.
- CNTW, 4: multiplier iteration counter width; must satisfy 2^CNTW > WIDTH.

Ports:
- clk  in  1  system clock; rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands/op present.
- in_ready  out  1  block can accept operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  4  opcode.
- cin  in  1  carry/borrow/shift-in bit.
- out_valid  out  1  result registers hold an untaken result.
- out_ready  in  1  consumer takes the result this cycle.
- result  out  WIDTH  result (low half for MUL).
- result_hi  out  WIDTH  high half of the MUL product; 0 for all other ops.
- cout  out  1  carry/borrow/shifted-out bit.
- zero  out  1  result (and result_hi for MUL) all zero.
- ovf  out  1  signed overflow.
- illegal  out  1  opcode was unused.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; the counter clears.
  - out_valid, result, result_hi, cout, zero, ovf, illegal all = 0.
  - in_ready = 0 while rst_n=0; it takes its normal value from the first clock after release.
- Reset mid-operation: an in-flight MUL or held result is discarded with no output.
- Accept condition: in_valid & in_ready at a rising edge.
  - in_ready = (state==IDLE) & (~out_valid | out_ready). Back-to-back single-cycle ops therefore sustain 1 op/cycle.
- Output handshake:
  - out_valid and all result/flag outputs stay stable until out_valid & out_ready.
  - out_valid clears after the transfer unless a new result loads in the same edge.
- Opcodes (W = WIDTH, all arithmetic modulo 2^W):
  - 0 ADD: R = A+B; cout = carry out.
  - 1 SUB: R = A−B; cout = borrow (1 iff A<B unsigned).
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 ADC: R = A+B+cin; cout = carry.
  - 6 SBB: R = A−B−cin; cout = borrow.
  - 7 NOT: R = ~A.
  - 8 SHL: R = {A[W−2:0], cin}; cout = A[W−1].
  - 9 SHR: R = {cin, A[W−1:1]}; cout = A[0].
  - 10 MUL: unsigned {result_hi, result} = A*B; cout = 0.
  - 11–15 illegal: R = 0, cout = 0, illegal = 1.
- Flags:
  - ovf is the two's-complement overflow for ops 0, 1, 5, 6; 0 for all other ops.
  - cout = 0 for ops 2, 3, 4, 7.
  - zero is computed on the final registered result.
  - illegal = 0 for all legal ops.
- Latency:
  - Ops 0–9 and illegal: outputs register on the accept edge; out_valid = 1 the cycle after accept.
  - MUL: out_valid rises WIDTH+1 cycles after accept.
- State machine:
  - IDLE: on accept of MUL → MUL. Latch the multiplicand and multiplier, clear the accumulator, set counter = 0.
  - IDLE: on accept of any other op → stay in IDLE and load the outputs.
  - MUL: each cycle, if multiplier LSB = 1 add the multiplicand into the accumulator high half. Then shift {carry, acc} right by 1 and increment the counter.
  - MUL: when counter == WIDTH−1, perform the final step, load the outputs, set out_valid, go to DONE.
  - DONE: wait until no untaken result remains, then → IDLE.
  - in_ready is 0 throughout MUL and DONE.
- Simultaneous events: out_ready and a new accept in the same cycle give a seamless replacement with no bubble.
- Bubble insertion: if out_valid=1 and out_ready=0, no accept occurs (in_ready=0).

Test Plan:
1. Reset mid-MUL: assert rst_n=0 during the 4th MUL iteration → out_valid=0 immediately (asynchronously); after release, in_ready=1 and no stale result ever appears.
2. WIDTH=8, out_ready=1. Stream ADD 3+1, then SUB 2−1, then ADC 4+5+1 on consecutive cycles → results 4, 1, 10 on consecutive cycles, cout=0; in_ready stays 1.
3. ADD 128+128 → result=0, cout=1, zero=1, ovf=1. SUB 5−6 → result=255, cout=1, ovf=0. ADD 127+1 → result=128, ovf=1.
4. MUL 255×255 → result_hi=0xFE, result=0x01, out_valid exactly 9 cycles after accept, in_ready=0 during that time. MUL 0×77 → zero=1.
5. SHL a=0x81 cin=1 → result=0x03, cout=1. SHR a=0x81 cin=0 → result=0x40, cout=1. op=12 → result=0, illegal=1.
6. Backpressure: hold out_ready=0 for 5 cycles after an XOR 0xF0^0xFF → result=0x0F stays stable and in_ready=0. Raising out_ready together with a new in_valid gives a transfer plus a new accept in the same edge.
